branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised successor to the single-entry jump predictor in the decode stage.
- Direct-mapped branch target buffer: each entry holds a valid bit, tag, target and N-bit saturating direction counter.
- Looked up combinationally with the IF/ID PC. Updated one branch per cycle from the resolving stage.
- Keeps a saturating mispredict counter for performance bring-up.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, at least 2. IDX_W = log2(ENTRIES).
- ADDR_W, 16, PC and target width.
- CTR_W, 2, direction counter width, at least 1.
- GHR_W, 4, global history width; at most IDX_W. Used only with the optional feature.
- CNT_W, 16, mispredict counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- lookup_pc  in  ADDR_W  PC of the instruction being predicted.
- pcinc  in  ADDR_W  lookup_pc+1; the fall-through address.
- pred_hit  out  1  entry is valid and its tag matches.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  next-PC prediction.
- pred_hist  out  GHR_W  history snapshot; travels with the branch down the pipe.
- upd_en  in  1  one resolved branch this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual target.
- upd_mispredict  in  1  direction or target was mispredicted; qualified by upd_en.
- upd_hist  in  GHR_W  the pred_hist value returned with this branch.
- inval_all  in  1  invalidate the whole table; used on context change.
- mispred_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low: when reset==0 at a rising edge, the block resets.
- Reset state:
  - All valid bits 0.
  - All counters weakly-not-taken: value 2^(CTR_W-1)-1, i.e. 01 for CTR_W=2. For CTR_W=1 the value is 0.
  - mispred_cnt=0; GHR=0.
  - Consequences: pred_hit=0, pred_taken=0, pred_target=pcinc.
- Index and tag:
  - idx = lookup_pc[IDX_W-1:0]. With the optional feature, idx is XORed with the history.
  - tag = lookup_pc[ADDR_W-1:IDX_W].
  - The update side uses upd_pc in the same way.
- Lookup (purely combinational, zero latency):
  - pred_hit = valid[idx] and tag equal.
  - pred_taken = pred_hit and counter MSB.
  - pred_target = target[idx] when pred_taken, else pcinc.
- Update, on an edge with reset==1 and upd_en==1:
  - Hit, taken: counter increments, saturating at all-ones; target[idx] <= upd_target.
  - Hit, not taken: counter decrements, saturating at 0; target is unchanged.
  - Miss, taken: allocate. valid <= 1, tag, target, counter <= 2^(CTR_W-1), which is weakly-taken. Any previous occupant is overwritten.
  - Miss, not taken: no allocation. Table unchanged.
- Read-during-write: a lookup in the same cycle as an update to the same index sees the old contents. There is no bypass; the new contents are visible from the next cycle.
- mispred_cnt: increments on upd_en and upd_mispredict. Holds at all-ones (saturates; no wrap).
- inval_all: clears all valid bits at the edge. Counters and targets keep their values.
- inval_all together with upd_en:
  - inval_all wins for the table; the table write is dropped.
  - mispred_cnt and GHR still update.
- Reset asserted mid-stream: overrides all other inputs that cycle.
- upd_mispredict with upd_en=0 is ignored.

Optional Feature:
- Macro: BPRED_GSHARE_EN.
- Defined:
  - A GHR_W-bit global history register shifts left on every upd_en, taking upd_taken into bit 0.
  - Lookup index is lookup_pc[IDX_W-1:0] XOR zero-extended GHR.
  - pred_hist = GHR.
  - Update index is upd_pc[IDX_W-1:0] XOR zero-extended upd_hist.
  - The tag is still taken from the PC.
  - On a mispredict, the GHR is restored to {upd_hist[GHR_W-2:0], upd_taken} instead of shifting. For GHR_W=1 it becomes upd_taken.
- Undefined:
  - No GHR is built; pred_hist drives 0; upd_hist is ignored.
  - Indexing uses PC bits only.

Test Plan:
- Reset: hold reset=0 for 2 cycles, lookup_pc=0x0012, pcinc=0x0013 -> pred_hit=0, pred_taken=0, pred_target=0x0013, mispred_cnt=0.
- Allocate and saturate: update pc=0x0012 taken, target=0x0040 -> next cycle pred_hit=1, pred_taken=1, pred_target=0x0040, counter=10. A second taken update -> counter=11. A third -> stays 11.
- Hysteresis: from counter 11, two not-taken updates -> counter 01 and pred_taken=0, pred_target=pcinc. A not-taken update to a missing pc=0x0033 -> pred_hit stays 0.
- Conflict and same-cycle read: with the entry for 0x0012 present, taken update of pc=0x0022 (same idx 2) with lookup_pc=0x0012 in the same cycle -> that cycle hit on 0x0012 with target 0x0040. Next cycle 0x0012 misses and 0x0022 hits.
- Invalidate priority: inval_all=1 together with upd_en, upd_mispredict=1 -> all entries miss next cycle and mispred_cnt increments. Force mispred_cnt to 0xFFFF (CNT_W=16) and mispredict again -> stays 0xFFFF.
- Gshare, macro defined: GHR=0000; four taken updates -> GHR=1111 and lookup of pc=0x0010 uses idx 0xF. A mispredicted update with upd_hist=0101, upd_taken=0 -> GHR=1010.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped branch target buffer with per-entry saturating
//            direction counters, zero-latency lookup, one update per cycle
//            and a saturating mispredict counter.
//            Optional gshare indexing: define BPRED_GSHARE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 16,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  input  logic [ADDR_W-1:0] pcinc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [GHR_W-1:0]  pred_hist,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic [GHR_W-1:0]  upd_hist,
  input  logic              inval_all,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;

  // Weakly-not-taken sits just below the MSB flip; weakly-taken just above.
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [ADDR_W-1:0]  tgt_mem [ENTRIES];
  logic [CTR_W-1:0]   ctr_mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W];

`ifdef BPRED_GSHARE_EN
  logic [GHR_W-1:0] ghr;
  logic [GHR_W-1:0] ghr_shift;
  logic [GHR_W-1:0] ghr_restore;

  // A one-bit history has nothing to shift; it simply records the outcome.
  generate
    if (GHR_W == 1) begin : g_ghr_w1
      assign ghr_shift   = upd_taken;
      assign ghr_restore = upd_taken;
    end else begin : g_ghr_wn
      assign ghr_shift   = {ghr[GHR_W-2:0], upd_taken};
      assign ghr_restore = {upd_hist[GHR_W-2:0], upd_taken};
    end
  endgenerate

  assign lk_idx    = lookup_pc[IDX_W-1:0] ^ IDX_W'(ghr);
  assign up_idx    = upd_pc[IDX_W-1:0] ^ IDX_W'(upd_hist);
  assign pred_hist = ghr;

  // Global history: speculative shift, repaired from the branch's snapshot on mispredict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr <= '0;
    end else if (upd_en) begin
      ghr <= upd_mispredict ? ghr_restore : ghr_shift;
    end
  end
`else
  logic unused_hist;
  assign unused_hist = ^upd_hist;
  assign lk_idx      = lookup_pc[IDX_W-1:0];
  assign up_idx      = upd_pc[IDX_W-1:0];
  assign pred_hist   = '0;
`endif

  // Combinational lookup; no bypass from a same-cycle update.
  always_comb begin
    pred_hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_mem[lk_idx][CTR_W-1];
    pred_target = pred_taken ? tgt_mem[lk_idx] : pcinc;
  end

  assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

  // Table write: invalidate beats update; not-taken misses never allocate.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_mem[i] <= CTR_WNT;
        tag_mem[i] <= '0;
        tgt_mem[i] <= '0;
      end
    end else if (inval_all) begin
      valid <= '0;
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_mem[up_idx] != CTR_MAX) ctr_mem[up_idx] <= ctr_mem[up_idx] + CTR_W'(1);
          tgt_mem[up_idx] <= upd_target;
        end else if (ctr_mem[up_idx] != '0) begin
          ctr_mem[up_idx] <= ctr_mem[up_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        valid[up_idx]   <= 1'b1;
        tag_mem[up_idx] <= up_tag;
        tgt_mem[up_idx] <= upd_target;
        ctr_mem[up_idx] <= CTR_WT;
      end
    end
  end

  // Mispredict counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mispred_cnt <= '0;
    end else if (upd_en && upd_mispredict && (mispred_cnt != {CNT_W{1'b1}})) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
